// File: rtl/printer_model.sv
// Printer endpoint: rising-edge strobe capture, per-character busy time, column/line
// tracking, character counter and sticky overrun. PRINTER_RANDOM_DELAY_EN adds LFSR jitter.
module printer_model #(
  parameter int          PRINT_CYCLES = 4,
  parameter int          LINE_LEN     = 8,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_tr,
  input  logic [7:0]                  i_pd,
  output logic                        o_rdy,
  output logic [7:0]                  o_char,
  output logic                        o_char_valid,
  output logic                        o_line_done,
  output logic [$clog2(LINE_LEN)-1:0] o_col,
  output logic [15:0]                 o_count,
  output logic                        o_overrun
);

  localparam int CW   = $clog2(PRINT_CYCLES + 8);
  localparam int COLW = $clog2(LINE_LEN);
  localparam logic [COLW-1:0] COL_LAST = COLW'(LINE_LEN - 1);

  localparam logic [0:0] ST_READY = 1'b0;
  localparam logic [0:0] ST_BUSY  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic            tr_q;
  logic            rdy_q, rdy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      char_q, char_d;
  logic            valid_q, valid_d;
  logic            line_done_q, line_done_d;
  logic [COLW-1:0] col_q, col_d;
  logic [15:0]     count_q, count_d;
  logic            overrun_q, overrun_d;
  logic            accept;
  logic [CW-1:0]   busy_load;

`ifdef PRINTER_RANDOM_DELAY_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign busy_load = CW'(PRINT_CYCLES - 1) + CW'(lfsr_q[2:0]);
`else
  assign busy_load = CW'(PRINT_CYCLES - 1);
`endif

  // Held strobes count once: only a low-to-high transition is an accept event.
  assign accept = i_tr & ~tr_q;

  always_comb begin
    state_d     = state_q;
    rdy_d       = rdy_q;
    cnt_d       = cnt_q;
    char_d      = char_q;
    valid_d     = 1'b0;
    line_done_d = 1'b0;
    col_d       = col_q;
    count_d     = count_q;
    overrun_d   = overrun_q;
`ifdef PRINTER_RANDOM_DELAY_EN
    lfsr_d      = lfsr_q;
`endif
    case (state_q)
      ST_READY: begin
        if (accept) begin
          state_d = ST_BUSY;
          rdy_d   = 1'b0;
          cnt_d   = busy_load;
          char_d  = i_pd;
          valid_d = 1'b1;
          count_d = count_q + 16'd1;
          if (i_pd == 8'h0A || col_q == COL_LAST) begin
            line_done_d = 1'b1;
            col_d       = '0;
          end else begin
            col_d = col_q + COLW'(1);
          end
`ifdef PRINTER_RANDOM_DELAY_EN
          lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
        end
      end
      ST_BUSY: begin
        // A new character while printing is dropped; only the overrun flag records it.
        if (accept) overrun_d = 1'b1;
        if (cnt_q == '0) begin
          rdy_d   = 1'b1;
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_READY;
      tr_q        <= 1'b0;
      rdy_q       <= 1'b1;
      cnt_q       <= '0;
      char_q      <= 8'h00;
      valid_q     <= 1'b0;
      line_done_q <= 1'b0;
      col_q       <= '0;
      count_q     <= 16'h0000;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tr_q        <= i_tr;
      rdy_q       <= rdy_d;
      cnt_q       <= cnt_d;
      char_q      <= char_d;
      valid_q     <= valid_d;
      line_done_q <= line_done_d;
      col_q       <= col_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef PRINTER_RANDOM_DELAY_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end
`endif

  assign o_rdy        = rdy_q;
  assign o_char       = char_q;
  assign o_char_valid = valid_q;
  assign o_line_done  = line_done_q;
  assign o_col        = col_q;
  assign o_count      = count_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_printer_model.sv
// Bench for printer_model: directed scenarios plus random strobes, every cycle compared
// against a cycle-level behavioural model of the printer.
module tb_printer_model;
  localparam int P = 4;
  localparam int L = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       tr;
  logic [7:0] pd;
  logic       rdy, char_valid, line_done, overrun;
  logic [7:0] chr;
  logic [2:0] col;
  logic [15:0] count;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  int          m_busy;
  logic        m_prev_tr;
  logic [7:0]  m_char;
  logic [15:0] m_count;
  int          m_col;
  logic        m_ovr, m_valid, m_ld;
  logic [7:0]  m_lfsr;

  printer_model #(.PRINT_CYCLES(P), .LINE_LEN(L), .LFSR_SEED(8'hA5)) dut (
    .i_clk(clk), .i_rst(rst), .i_tr(tr), .i_pd(pd),
    .o_rdy(rdy), .o_char(chr), .o_char_valid(char_valid), .o_line_done(line_done),
    .o_col(col), .o_count(count), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string where);
    check({where, ".rdy"},        32'(rdy),        32'(m_busy == 0));
    check({where, ".char"},       32'(chr),        32'(m_char));
    check({where, ".valid"},      32'(char_valid), 32'(m_valid));
    check({where, ".line_done"},  32'(line_done),  32'(m_ld));
    check({where, ".col"},        32'(col),        32'(m_col));
    check({where, ".count"},      32'(count),      32'(m_count));
    check({where, ".overrun"},    32'(overrun),    32'(m_ovr));
  endtask

  task automatic model_reset();
    m_busy = 0; m_prev_tr = 1'b0; m_char = 8'h00; m_count = 16'h0000;
    m_col = 0; m_ovr = 1'b0; m_valid = 1'b0; m_ld = 1'b0; m_lfsr = 8'hA5;
  endtask

  // One clock edge of the printer as seen from outside: busy_left counts low cycles still owed.
  task automatic model_edge(input logic t, input logic [7:0] d);
    logic acc;
    int   extra;
    acc = t && !m_prev_tr;
    m_prev_tr = t;
    m_valid = 1'b0;
    m_ld = 1'b0;
    if (m_busy > 0) begin
      m_busy--;
      if (acc) m_ovr = 1'b1;
    end else if (acc) begin
      m_char = d;
      m_count = m_count + 16'd1;
      m_valid = 1'b1;
      if (d == 8'h0A || m_col == L - 1) begin
        m_ld = 1'b1;
        m_col = 0;
      end else begin
        m_col++;
      end
      extra = 0;
`ifdef PRINTER_RANDOM_DELAY_EN
      extra = int'(m_lfsr % 8);
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
      m_busy = P + extra;
    end
  endtask

  task automatic step(input logic t, input logic [7:0] d, input string where);
    @(negedge clk);
    tr = t;
    pd = d;
    @(posedge clk);
    model_edge(t, d);
    #1;
    check_all(where);
  endtask

  task automatic send(input logic [7:0] d, input string where);
    int guard;
    step(1'b1, d, where);
    step(1'b0, d, where);
    guard = 0;
    while (m_busy > 0 && guard < 40) begin
      step(1'b0, d, where);
      guard++;
    end
    check({where, ".ready_timeout"}, 32'(m_busy), 32'd0);
  endtask

  task automatic do_reset(input string where);
    @(negedge clk);
    tr = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(where);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tr = 1'b0; pd = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    send(8'h41, "t1_single");

    do_reset("t2_rst");
    for (int i = 0; i < 8; i++) send(8'h30 + 8'(i), "t2_line");

    do_reset("t3_rst");
    send(8'h61, "t3_a");
    send(8'h0A, "t3_nl");

    do_reset("t4_rst");
    step(1'b1, 8'h41, "t4_first");
    step(1'b0, 8'h41, "t4_gap");
    step(1'b1, 8'h42, "t4_over");
    for (int i = 0; i < 6; i++) step(1'b0, 8'h42, "t4_tail");
    send(8'h43, "t4_sticky");

    do_reset("t5_rst");
    for (int i = 0; i < 10; i++) step(1'b1, 8'h55, "t5_hold");
    for (int i = 0; i < 8; i++) step(1'b0, 8'h55, "t5_release");
    step(1'b1, 8'h56, "t5_accept");
    step(1'b0, 8'h56, "t5_busy");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("t5_async_rst");
    @(negedge clk);
    rst = 1'b0;

    do_reset("t6_rst");
    send(8'h21, "t6_pre");
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    m_count = 16'hFFFF;
    send(8'h22, "t6_wrap");
    send(8'h23, "t6_after");

    do_reset("rnd_rst");
    for (int i = 0; i < 600; i++) begin
      logic       t;
      logic [7:0] d;
      t = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
      step(t, d, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
